uart_rx_receiver: RTL and testbench

//  Serial UART receiver; the receive-side counterpart of the UART TX register/transmitter path.
//  - Samples the asynchronous rx line and frames 8N1 characters at the programmed clocks-per-bit divisor.
//  - Holds each received byte in a one-deep holding register with a valid flag for the bus register block to read.
//  - Flags framing and overrun errors.

---
 rtl/uart_rx_receiver.sv | 149 ++++++++++++++
 tb/tb_uart_rx_receiver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_receiver.sv
// 8N1 UART receiver: mid-bit sampling at max(baud_div,2) clks/bit into a one-deep holding register.
// Latency: rx_valid rises ~SYNC_STAGES + Neff/2 + 9*Neff clks after the start edge; no backpressure (an unread byte causes overrun).
module uart_rx_receiver #(
  parameter int width       = 32,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 rx_enable,
  input  logic [width-1:0]     baud_div,
  input  logic                 data_read,
  input  logic                 err_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  state_t                 state_q;
  logic [width-1:0]       cnt_q;
  logic [width-1:0]       neff_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   ovr_q;
  logic                   busy_q;

  logic                   rx_s;
  logic                   fall;
  logic [width-1:0]       neff_d;
  logic [width-1:0]       half_m1;
  logic [width-1:0]       full_m1;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign fall    = rx_prev_q & ~rx_s;
  assign neff_d  = (baud_div < width'(2)) ? width'(2) : baud_div;
  assign half_m1 = (neff_q >> 1) - width'(1);
  assign full_m1 = neff_q - width'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_serial};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neff_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Flag sets below are later assignments, so they override a same-cycle clear/pop.
      if (err_clear) begin
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (data_read && valid_q) valid_q <= 1'b0;

      if (state_q != IDLE && !rx_enable) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_enable && fall) begin
              state_q <= START;
              cnt_q   <= '0;
              neff_q  <= neff_d;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (cnt_q == half_m1) begin
              cnt_q <= '0;
              bit_q <= '0;
              if (!rx_s) begin
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + width'(1);
            end
          end
          DATA: begin
            if (cnt_q == full_m1) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_q   <= bit_q + BW'(1);
              if (bit_q == BW'(DATA_BITS - 1)) state_q <= STOP;
            end else begin
              cnt_q <= cnt_q + width'(1);
            end
          end
          STOP: begin
            if (cnt_q == full_m1) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (!valid_q || data_read) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
              if (!rx_s) ferr_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + width'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_receiver.sv
// Bench for uart_rx_receiver: expected bytes queued when a frame is driven, popped when rx_valid is observed.
module tb_uart_rx_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_serial;
  logic        rx_enable;
  logic [31:0] baud_div;
  logic        data_read;
  logic        err_clear;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_error;
  logic        overrun;
  logic        rx_busy;

  int          n_pass = 0;
  int          n_chk  = 0;
  int          valid_at;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;

  always #5 clk = ~clk;

  uart_rx_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .rx_enable  (rx_enable),
    .baud_div   (baud_div),
    .data_read  (data_read),
    .err_clear  (err_clear),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  // Drives one frame starting at a falling clock edge (c=0), n clks per bit, plus an idle-high tail.
  // valid_at is the first c at which rx_valid is seen high.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int n,
                            input bit read_at_stop, input int max_clks);
    logic [9:0] bits;
    int total;
    bits  = {stop_b, d, 1'b0};
    total = 10 * n + n / 2 + 4;
    if (max_clks < total) total = max_clks;
    valid_at = -1;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (rx_valid && valid_at < 0) valid_at = c;
      rx_serial = (c < 10 * n) ? bits[c / n] : 1'b1;
      data_read = read_at_stop && (c == 2 + n / 2 + 9 * n);
    end
    data_read = 1'b0;
  endtask

  task automatic pulse_read();
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_serial = 1'b1; rx_enable = 1'b1; baud_div = 32'd16;
    data_read = 1'b0; err_clear = 1'b0;
    #1;
    n_chk++;
    if ({rx_data, rx_valid, frame_error, overrun, rx_busy} !== 12'h000)
      $display("FAIL reset_outputs: got %h want 000", {rx_data, rx_valid, frame_error, overrun, rx_busy});
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if ({rx_valid, rx_busy} !== 2'b00)
      $display("FAIL idle_after_reset: valid/busy=%b want 00", {rx_valid, rx_busy});
    else n_pass++;
  endtask

  task automatic test_basic();
    baud_div = 32'd16;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 16, 1'b0, 1000);
    n_chk++;
    if (valid_at !== 155) $display("FAIL basic_latency: valid at c=%0d want 155", valid_at);
    else n_pass++;
    exp_b = exp_q.pop_front();
    n_chk++;
    if (rx_data !== exp_b || rx_valid !== 1'b1)
      $display("FAIL basic_data: data=%h valid=%b want %h 1", rx_data, rx_valid, exp_b);
    else n_pass++;
    n_chk++;
    if ({frame_error, overrun, rx_busy} !== 3'b000)
      $display("FAIL basic_flags: ferr/ovr/busy=%b want 000", {frame_error, overrun, rx_busy});
    else n_pass++;
    pulse_read();
    n_chk++;
    if (rx_valid !== 1'b0 || rx_data !== exp_b)
      $display("FAIL basic_pop: valid=%b data=%h want 0 %h", rx_valid, rx_data, exp_b);
    else n_pass++;
  endtask

  task automatic test_glitch();
    baud_div = 32'd16;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (rx_busy !== 1'b1) $display("FAIL glitch_busy_start: busy=%b want 1", rx_busy);
    else n_pass++;
    rx_serial = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++;
    if ({rx_busy, rx_valid, frame_error} !== 3'b000)
      $display("FAIL glitch_reject: busy/valid/ferr=%b want 000", {rx_busy, rx_valid, frame_error});
    else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_framing();
    baud_div = 32'd16;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 16, 1'b0, 160);
    repeat (48) @(negedge clk);
    exp_b = exp_q.pop_front();
    n_chk++;
    if (rx_data !== exp_b || rx_valid !== 1'b1 || frame_error !== 1'b1)
      $display("FAIL framing_data: data=%h valid=%b ferr=%b want %h 1 1", rx_data, rx_valid, frame_error, exp_b);
    else n_pass++;
    n_chk++;
    if (rx_busy !== 1'b0) $display("FAIL framing_no_restart: busy=%b want 0", rx_busy);
    else n_pass++;
    rx_serial = 1'b1;
    pulse_clear();
    n_chk++;
    if (frame_error !== 1'b0) $display("FAIL framing_clear: ferr=%b want 0", frame_error);
    else n_pass++;
    pulse_read();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overrun();
    baud_div = 32'd16;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 16, 1'b0, 1000);
    send_frame(8'h22, 1'b1, 16, 1'b0, 1000);
    exp_b = exp_q.pop_front();
    n_chk++;
    if (rx_data !== exp_b || rx_valid !== 1'b1 || overrun !== 1'b1)
      $display("FAIL overrun_keep: data=%h valid=%b ovr=%b want %h 1 1", rx_data, rx_valid, overrun, exp_b);
    else n_pass++;
    pulse_clear();
    n_chk++;
    if (overrun !== 1'b0 || rx_valid !== 1'b1)
      $display("FAIL overrun_clear: ovr=%b valid=%b want 0 1", overrun, rx_valid);
    else n_pass++;
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 16, 1'b1, 1000);
    exp_b = exp_q.pop_front();
    n_chk++;
    if (rx_data !== exp_b || rx_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL overrun_read_same_cycle: data=%h valid=%b ovr=%b want %h 1 0", rx_data, rx_valid, overrun, exp_b);
    else n_pass++;
    pulse_read();
  endtask

  task automatic test_reset_abort();
    baud_div = 32'd16;
    send_frame(8'h33, 1'b1, 16, 1'b0, 1000);
    send_frame(8'h77, 1'b1, 16, 1'b0, 80);
    reset = 1'b1;
    #1;
    n_chk++;
    if ({rx_data, rx_valid, frame_error, overrun, rx_busy} !== 12'h000)
      $display("FAIL reset_midframe: got %h want 000", {rx_data, rx_valid, frame_error, overrun, rx_busy});
    else n_pass++;
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 16, 1'b0, 1000);
    exp_b = exp_q.pop_front();
    n_chk++;
    if (rx_data !== exp_b || {rx_valid, frame_error, overrun} !== 3'b100)
      $display("FAIL after_reset_frame: data=%h v/fe/ov=%b want %h 100", rx_data, {rx_valid, frame_error, overrun}, exp_b);
    else n_pass++;
    pulse_read();
    send_frame(8'h96, 1'b1, 16, 1'b0, 60);
    n_chk++;
    if (rx_busy !== 1'b1) $display("FAIL enable_drop_busy: busy=%b want 1", rx_busy);
    else n_pass++;
    rx_enable = 1'b0;
    rx_serial = 1'b1;
    repeat (200) @(negedge clk);
    n_chk++;
    if ({rx_busy, rx_valid, frame_error, overrun} !== 4'b0000)
      $display("FAIL enable_drop_abort: busy/v/fe/ov=%b want 0000", {rx_busy, rx_valid, frame_error, overrun});
    else n_pass++;
    rx_enable = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_divisor();
    for (int k = 0; k < 2; k++) begin
      baud_div = (k == 0) ? 32'd0 : 32'd2;
      exp_q.push_back(8'hF0);
      send_frame(8'hF0, 1'b1, 2, 1'b0, 1000);
      exp_b = exp_q.pop_front();
      n_chk++;
      if (rx_data !== exp_b || rx_valid !== 1'b1 || frame_error !== 1'b0)
        $display("FAIL divisor_%0d_data: data=%h valid=%b ferr=%b want %h 1 0", k, rx_data, rx_valid, frame_error, exp_b);
      else n_pass++;
      n_chk++;
      if (valid_at !== 22) $display("FAIL divisor_%0d_latency: valid at c=%0d want 22", k, valid_at);
      else n_pass++;
      pulse_read();
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_abort();
    test_divisor();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
